// File: rtl/dot_prod_pkg.sv
// Shared types and width helpers for the dot-product peak sink.
// Magnitude mode is selected by DOT_PROD_SINK_SQUARED_MAG_EN (abs mode when undefined).
package dot_prod_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int DEFAULT_SUM_W = 16;

`ifdef DOT_PROD_SINK_SQUARED_MAG_EN
    localparam bit SQUARED_MAG = 1'b1;
`else
    localparam bit SQUARED_MAG = 1'b0;
`endif

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Abs mode: |i|+|q| reaches 2^W, needing W+1 bits; squared needs 2W+1.
    function automatic int mag_bits(input int wi, input int wq, input bit squared);
        return squared ? (2 * max_w(wi, wq) + 1) : (max_w(wi, wq) + 1);
    endfunction

endpackage

// File: rtl/dot_prod_sink_iq_mag.sv
// Combinational I/Q magnitude: |i|+|q| by default, i*i+q*q when
// DOT_PROD_SINK_SQUARED_MAG_EN is defined.
module iq_mag
    import dot_prod_pkg::*;
#(
    parameter int I_W   = DEFAULT_SUM_W,
    parameter int Q_W   = DEFAULT_SUM_W,
    parameter int MAG_W = mag_bits(DEFAULT_SUM_W, DEFAULT_SUM_W, SQUARED_MAG)
) (
    input  logic signed [I_W-1:0]   i,
    input  logic signed [Q_W-1:0]   q,
    output logic        [MAG_W-1:0] mag
);

    localparam int W  = max_w(I_W, Q_W);
    localparam int EW = W + 1;

    // One guard bit so the most-negative input negates without wrapping.
    logic signed [EW-1:0] i_ext;
    logic signed [EW-1:0] q_ext;

    assign i_ext = EW'(i);
    assign q_ext = EW'(q);

`ifdef DOT_PROD_SINK_SQUARED_MAG_EN
    localparam int SW = 2 * W + 2;

    logic signed [SW-1:0] i_sq;
    logic signed [SW-1:0] q_sq;

    always_comb begin
        i_sq = SW'(i_ext) * SW'(i_ext);
        q_sq = SW'(q_ext) * SW'(q_ext);
        mag  = MAG_W'($unsigned(i_sq + q_sq));
    end
`else
    logic [EW-1:0] i_abs;
    logic [EW-1:0] q_abs;

    always_comb begin
        i_abs = i_ext[EW-1] ? $unsigned(-i_ext) : $unsigned(i_ext);
        q_abs = q_ext[EW-1] ? $unsigned(-q_ext) : $unsigned(q_ext);
        mag   = MAG_W'(i_abs) + MAG_W'(q_abs);
    end
`endif

endmodule

// File: rtl/dot_prod_sink.sv
// Frame peak finder: tracks the largest I/Q magnitude over LENGTH products and
// presents it with its index. Squared magnitude via DOT_PROD_SINK_SQUARED_MAG_EN.
//
//   state | meaning
//   ACCUM | accepting products, updating running peak
//   DONE  | holding peak result until downstream handshake
module dot_prod_sink
    import dot_prod_pkg::*;
#(
    parameter  int SUM_I_SIZE = 16,
    parameter  int SUM_Q_SIZE = 16,
    parameter  int LENGTH     = 1024,
    parameter  int INDEX_BITS = 10,
    localparam int MAG_BITS   = mag_bits(SUM_I_SIZE, SUM_Q_SIZE, SQUARED_MAG)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_axis_product_tvalid,
    output logic                         m_axis_product_tready,
    input  logic signed [SUM_I_SIZE-1:0] i,
    input  logic signed [SUM_Q_SIZE-1:0] q,
    output logic                         s_axis_peak_tvalid,
    input  logic                         m_axis_peak_tready,
    output logic        [MAG_BITS-1:0]   peak_mag,
    output logic        [INDEX_BITS-1:0] peak_index
);

    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(LENGTH - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [INDEX_BITS-1:0]   cnt;
    logic [MAG_BITS-1:0]     mag;
    logic                    accept;
    logic                    last_accept;
    logic                    peak_hs;
    logic                    take;

    iq_mag #(
        .I_W   (SUM_I_SIZE),
        .Q_W   (SUM_Q_SIZE),
        .MAG_W (MAG_BITS)
    ) u_iq_mag (
        .i   (i),
        .q   (q),
        .mag (mag)
    );

    assign accept      = s_axis_product_tvalid && m_axis_product_tready;
    assign last_accept = accept && (cnt == LAST_IDX);
    assign peak_hs     = s_axis_peak_tvalid && m_axis_peak_tready;
    // Strict compare keeps the earliest index on ties.
    assign take        = accept && ((cnt == '0) || (mag > peak_mag));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (last_accept) state_nxt = DONE;
            DONE:    if (peak_hs)     state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        m_axis_product_tready = (state == ACCUM);
        s_axis_peak_tvalid    = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= '0;
            peak_mag   <= '0;
            peak_index <= '0;
        end else if (peak_hs) begin
            cnt        <= '0;
            peak_mag   <= '0;
            peak_index <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (take) begin
                peak_mag   <= mag;
                peak_index <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_dot_prod_sink.sv
// Scoreboard bench for dot_prod_sink (LENGTH=4, 8-bit I/Q); expectations
// follow DOT_PROD_SINK_SQUARED_MAG_EN when it is defined for the build.
module tb_dot_prod_sink;

    localparam int L  = 4;
    localparam int IW = 8;
    localparam int QW = 8;
    localparam int XB = 2;
`ifdef DOT_PROD_SINK_SQUARED_MAG_EN
    localparam bit SQ = 1'b1;
    localparam int MB = 2 * IW + 1;
`else
    localparam bit SQ = 1'b0;
    localparam int MB = IW + 1;
`endif

    typedef struct {
        int mag;
        int idx;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 s_axis_product_tvalid = 1'b0;
    logic                 m_axis_product_tready;
    logic signed [IW-1:0] i = '0;
    logic signed [QW-1:0] q = '0;
    logic                 s_axis_peak_tvalid;
    logic                 m_axis_peak_tready = 1'b1;
    logic [MB-1:0]        peak_mag;
    logic [XB-1:0]        peak_index;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    dot_prod_sink #(
        .SUM_I_SIZE (IW),
        .SUM_Q_SIZE (QW),
        .LENGTH     (L),
        .INDEX_BITS (XB)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .s_axis_product_tvalid (s_axis_product_tvalid),
        .m_axis_product_tready (m_axis_product_tready),
        .i                     (i),
        .q                     (q),
        .s_axis_peak_tvalid    (s_axis_peak_tvalid),
        .m_axis_peak_tready    (m_axis_peak_tready),
        .peak_mag              (peak_mag),
        .peak_index            (peak_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one pop per peak handshake, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && s_axis_peak_tvalid && m_axis_peak_tready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_peak: got mag %0d index %0d expected none", peak_mag, peak_index);
            end else begin
                e = sb.pop_front();
                chk("peak_mag", 32'(peak_mag), e.mag);
                chk("peak_index", 32'(peak_index), e.idx);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ii, input int qq, input bit last, input int gap);
        repeat (gap) begin
            s_axis_product_tvalid = 1'b0;
            cyc();
        end
        i = IW'(ii);
        q = QW'(qq);
        s_axis_product_tvalid = 1'b1;
        chk("product_tready", 32'(m_axis_product_tready), 1);
        cyc();
        s_axis_product_tvalid = 1'b0;
        if (last) chk("peak_latency", 32'(s_axis_peak_tvalid), 1);
        else      chk("accum_no_peak", 32'(s_axis_peak_tvalid), 0);
    endtask

    task automatic send_frame(input int fi[4], input int fq[4], input int em, input int ex,
                              input bit gaps);
        exp_t e;
        e.mag = em;
        e.idx = ex;
        sb.push_back(e);
        for (int k = 0; k < L; k++)
            send(fi[k], fq[k], k == L - 1, gaps ? int'($urandom_range(0, 3)) : 0);
        if (m_axis_peak_tready) begin
            cyc();
            chk("rearm_tready", 32'(m_axis_product_tready), 1);
            chk("rearm_tvalid", 32'(s_axis_peak_tvalid), 0);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_tready", 32'(m_axis_product_tready), 1);
        chk("rst_tvalid", 32'(s_axis_peak_tvalid), 0);
        chk("rst_mag", 32'(peak_mag), 0);
        chk("rst_index", 32'(peak_index), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset_n = 1'b0;
        repeat (3) cyc();
        chk_reset_state();
        reset_n = 1'b1;
        cyc();

        // Basic frame: abs 7,10,11,2 / squared 25,100,85,2
        send_frame('{3, 10, -2, 1}, '{-4, 0, -9, 1}, SQ ? 100 : 11, SQ ? 1 : 2, 1'b0);
        // Ties keep the earliest index
        send_frame('{5, 0, -5, 1}, '{0, -5, 0, 0}, SQ ? 25 : 5, 0, 1'b0);
        // All-zero frame: first product must still be taken
        send_frame('{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 1'b0);
        // Most-negative inputs
        send_frame('{1, 2, 3, -128}, '{0, 0, 0, -128}, SQ ? 32768 : 256, 3, 1'b0);
        send_frame('{127, -127, 0, -128}, '{-128, 127, 0, 127}, SQ ? 32513 : 255, 0, 1'b0);

        // Backpressure; tvalid driven in DONE must be ignored
        m_axis_peak_tready = 1'b0;
        send_frame('{3, 10, -2, 1}, '{-4, 0, -9, 1}, SQ ? 100 : 11, SQ ? 1 : 2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            s_axis_product_tvalid = 1'b1;
            i = 8'sd127;
            q = 8'sd127;
            cyc();
            chk("bp_tvalid", 32'(s_axis_peak_tvalid), 1);
            chk("bp_tready", 32'(m_axis_product_tready), 0);
            chk("bp_mag", 32'(peak_mag), SQ ? 100 : 11);
            chk("bp_index", 32'(peak_index), SQ ? 1 : 2);
        end
        s_axis_product_tvalid = 1'b0;
        m_axis_peak_tready = 1'b1;
        cyc();
        chk("release_tready", 32'(m_axis_product_tready), 1);
        chk("release_tvalid", 32'(s_axis_peak_tvalid), 0);
        // Counter must not have advanced during DONE
        send_frame('{0, 0, 6, 0}, '{1, 1, 0, 2}, SQ ? 36 : 6, 2, 1'b0);

        // Reset mid-frame discards the partial frame
        send(7, 7, 1'b0, 0);
        send(8, 8, 1'b0, 0);
        reset_n = 1'b0;
        cyc();
        chk_reset_state();
        reset_n = 1'b1;
        cyc();
        send_frame('{1, 2, 9, 0}, '{0, 0, 0, 0}, SQ ? 81 : 9, 2, 1'b0);

        // Random gaps must not change results
        for (int r = 0; r < 3; r++)
            send_frame('{3, 10, -2, 1}, '{-4, 0, -9, 1}, SQ ? 100 : 11, SQ ? 1 : 2, 1'b1);
        send_frame('{1, 2, 9, 0}, '{0, 0, 0, 0}, SQ ? 81 : 9, 2, 1'b1);

        repeat (3) cyc();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
